// File: rtl/arbiter_pkg.sv
// Shared definitions for the arbiter traffic clients: state encoding and
// counter-width helper.
package arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_REQ  = 2'd2
   } state_t;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int cnt_w(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised saturating up-counter with increment enable and
// synchronous clear.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != CNT_MAX))
         r_cnt <= r_cnt + W'(1);
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/burst_writer.sv
// Traffic-source client: waits PERIOD cycles, then writes a BURST_LEN burst of
// sequence-numbered, channel-tagged words over the req/busy handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | burst finished or never started; samples i_enable
//   WAIT    | counting PERIOD idle cycles before raising the request
//   REQ     | o_req high; one beat transfers per edge with i_busy low
module burst_writer
   import arbiter_pkg::*;
#(
   parameter int PERIOD    = 5,
   parameter int BURST_LEN = 4,
   parameter int SEQ_W     = 8,
   parameter int ID_W      = 2,
   parameter int CH_ID     = 0,
   parameter int STALL_W   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_busy,
   output logic                 o_req,
   output logic [ID_W+SEQ_W-1:0] o_data,
   output logic                 o_done,
   output logic [STALL_W-1:0]   o_stall_cnt
);

   localparam int PW = cnt_w(PERIOD);
   localparam int BW = cnt_w(BURST_LEN);

   localparam logic [PW-1:0]   P_LAST = PW'(PERIOD - 1);
   localparam logic [BW-1:0]   B_LAST = BW'(BURST_LEN - 1);
   localparam logic [ID_W-1:0] ID_TAG = ID_W'(CH_ID);

   state_t                  r_state;
   logic [PW-1:0]           r_period_cnt;
   logic [BW-1:0]           r_beat_cnt;
   logic [SEQ_W-1:0]        r_seq;
   logic                    r_req;
   logic [ID_W+SEQ_W-1:0]   r_data;
   logic                    r_done;

   logic [SEQ_W-1:0]        w_seq_nxt;
   logic                    w_stall_inc;

   assign w_seq_nxt   = r_seq + SEQ_W'(1);
   assign w_stall_inc = r_req & i_busy;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_period_cnt <= '0;
         r_beat_cnt   <= '0;
         r_seq        <= '0;
         r_req        <= 1'b0;
         r_data       <= '0;
         r_done       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (i_enable) begin
                  r_state      <= ST_WAIT;
                  r_period_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (r_period_cnt == P_LAST) begin
                  r_state    <= ST_REQ;
                  r_req      <= 1'b1;
                  r_data     <= {ID_TAG, r_seq};
                  r_beat_cnt <= '0;
               end else begin
                  r_period_cnt <= r_period_cnt + PW'(1);
               end
            end
            ST_REQ: begin
               // While stalled nothing changes: req and data hold for the arbiter.
               if (!i_busy) begin
                  r_seq <= w_seq_nxt;
                  if (r_beat_cnt == B_LAST) begin
                     r_req   <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BW'(1);
                     r_data     <= {ID_TAG, w_seq_nxt};
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_req   <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(
      .W (STALL_W)
   ) u_stall_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (1'b0),
      .i_inc   (w_stall_inc),
      .o_cnt   (o_stall_cnt)
   );

   assign o_req  = r_req;
   assign o_data = r_data;
   assign o_done = r_done;

`ifdef FORMAL
   logic          f_past_valid = 1'b0;
   logic [31:0]   f_beats      = '0;
   logic [31:0]   f_stall_run  = '0;

   always_ff @(posedge i_clk) begin
      f_past_valid <= 1'b1;
      if (i_reset || r_state == ST_IDLE) f_beats <= '0;
      else if (r_req && !i_busy)         f_beats <= f_beats + 32'd1;
      if (r_req && i_busy) f_stall_run <= f_stall_run + 32'd1;
      else                 f_stall_run <= '0;
   end

   always_comb begin
      assert (r_state == ST_IDLE || r_state == ST_WAIT || r_state == ST_REQ);
      assert (f_beats <= 32'(BURST_LEN));
   end

   always_ff @(posedge i_clk) begin
      if (f_past_valid && $past(r_req && i_busy) && !$past(i_reset)) begin
         assert ($stable(r_req));
         assert ($stable(r_data));
      end
      if (f_past_valid && $past(r_done) && !$past(i_reset))
         assert (!r_done);
      if (f_past_valid && r_done && !$past(i_reset))
         assert ($past(f_beats) == 32'(BURST_LEN - 1));
      if (BURST_LEN > 1)
         cover (f_stall_run >= 32'd2 && r_beat_cnt != '0);
   end
`endif

endmodule
